color_blob_locator: RTL and testbench
=====================================

Name: color_blob_locator

Overview:
- Consumer of the sampled reference colour (`color_sample`, Cr in [15:8], Cb in [7:0]) produced at the frame centre.
- Classifies every streamed CrCb pixel against that reference within a tolerance and accumulates x/y sums and a match count over the frame.
- At frame end, a sequential divider computes the blob centroid (ball position) for the plate controller.
- Sits between the camera YCrCb pixel stream and the ball-position registers.

Parameters:
- H_ACTIVE, 320, active pixels per line; frame end is pixel_x==H_ACTIVE-1 and pixel_y==V_ACTIVE-1.
- V_ACTIVE, 240, active lines per frame.
- TOL, 16, max absolute difference per channel (Cr and Cb) for a match, 0..255.
- MIN_COUNT, 64, minimum matched pixels for a valid detection.

Ports:
- clk_100M  in  1  system clock.
- rst_p  in  1  synchronous, active-high reset.
- en  in  1  enables pixel classification and accumulation.
- shift_clk_en  in  1  pixel-valid strobe; CrCb, pixel_x and pixel_y are sampled only when it is high.
- CrCb  in  16  pixel colour, Cr in [15:8], Cb in [7:0].
- pixel_x  in  12  column of the current pixel.
- pixel_y  in  12  row of the current pixel.
- color_sample  in  16  reference colour, same packing as CrCb.
- ball_x  out  12  centroid column.
- ball_y  out  12  centroid row.
- ball_found  out  1  last completed frame had count >= MIN_COUNT.
- ball_valid  out  1  one-cycle pulse when ball_x, ball_y and ball_found update.
- busy  out  1  high while the divider runs.
- overrun  out  1  sticky; a frame end arrived while busy.

Behaviour:
- One clock (clk_100M). Reset is synchronous and active-high (rst_p). All registers update on the rising edge of clk_100M.
- Reset clears all outputs to 0, clears the accumulators, and sets the state to IDLE.
- Match rule: |Cr-Cr_ref|<=TOL and |Cb-Cb_ref|<=TOL, both computed unsigned on 8 bits (difference exactly TOL matches).
- A pixel qualifies when shift_clk_en & en & match & pixel_x<H_ACTIVE & pixel_y<V_ACTIVE.
- On a qualifying pixel: sum_x+=pixel_x, sum_y+=pixel_y, count+=1.
  - sum_x and sum_y are 32-bit; count is 17-bit.
  - No saturation is needed for the default geometry.
- Frame end: shift_clk_en & pixel_x==H_ACTIVE-1 & pixel_y==V_ACTIVE-1, counted regardless of en. On frame end:
  - The final pixel's contribution is included.
  - Sums and count are snapshotted into divider registers.
  - The accumulators clear in the same cycle, so the next frame accumulates concurrently with the divide.
- FSM:
  - IDLE: waiting for frame end.
  - DIVIDE: 32-iteration restoring division, sum_x/count and sum_y/count in parallel, one quotient bit per cycle, busy=1.
  - DONE: 1 cycle; outputs load and ball_valid=1, then return to IDLE.
  - IDLE->DIVIDE on frame end.
  - DIVIDE->DONE after iteration 32.
  - DONE->IDLE unconditionally.
- Latency: ball_valid rises exactly 34 cycles after the frame-end pixel's clock edge. The latency is identical when count<MIN_COUNT.
- count<MIN_COUNT (including 0):
  - No divide is performed and the quotient is ignored, so division by zero is never possible.
  - ball_x and ball_y hold their previous values.
  - ball_found=0.
- count>=MIN_COUNT:
  - ball_x and ball_y take the truncated quotients, low 12 bits.
  - ball_found=1.
- Frame end while busy: the snapshot is dropped, the running divide completes unaffected, the accumulators still clear, and overrun is set (cleared only by reset).
- Reset mid-DIVIDE aborts immediately. The outputs go to 0 and no ball_valid is issued for the aborted frame.
- shift_clk_en low: inputs ignored and no accumulation occurs. Frame end requires shift_clk_en.
- color_sample is read combinationally per pixel. A change mid-frame takes effect on the next pixel.

Optional Feature:
- Macro: COLOR_BLOB_MASK_OUT_EN.
- When defined:
  - Adds output match_mask (1 bit) and match_mask_valid (1 bit), registered, one cycle after the sampled pixel.
  - match_mask is the raw match result ANDed with en.
  - match_mask_valid equals the delayed shift_clk_en.
  - Both reset to 0.
  - Used for the HDMI overlay.
- When undefined: neither port exists, and there are no extra registers.

Test Plan:
- Stream a 320x240 frame with color_sample=16'h9060, a 10x10 block of CrCb=16'h9262 at x100..109, y50..59, all other pixels 16'h2020, en=1 -> ball_valid 34 cycles after the last pixel; ball_x=104, ball_y=54, ball_found=1.
- Tolerance edge: TOL=16, color_sample=16'h8080; pixels 16'h9090 (diff 16) and 16'h9180 (diff 17) -> only 16'h9090 counted (verify with 64 vs 63 matching pixels via ball_found).
- A frame with exactly 63 matches after a valid frame (104,54) -> ball_found=0, ball_x=104 and ball_y=54 held, ball_valid still pulses at latency 34.
- en=0 for the entire frame containing the blob -> ball_found=0. The next frame with en=1 computes correctly, proving the accumulators cleared.
- Force a second frame end 10 cycles after the first -> overrun=1, the first result is delivered correctly, and only one ball_valid is issued.
- Assert rst_p at cycle 15 of DIVIDE -> busy=0 and outputs 0 the next cycle, no ball_valid; the following full frame yields the correct centroid.

Source files
------------

// File: rtl/color_blob_locator.sv
`default_nettype none
// ============================================================================
// Module   : color_blob_locator
// Brief    : Classifies CrCb pixels against a reference colour, accumulates
//            blob coordinate sums per frame and computes the centroid with a
//            32-cycle restoring divider. Optional mask output: COLOR_BLOB_MASK_OUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module color_blob_locator #(
    parameter int H_ACTIVE  = 320,
    parameter int V_ACTIVE  = 240,
    parameter int TOL       = 16,
    parameter int MIN_COUNT = 64
) (
    input  logic        clk_100M,
    input  logic        rst_p,
    input  logic        en,
    input  logic        shift_clk_en,
    input  logic [15:0] CrCb,
    input  logic [11:0] pixel_x,
    input  logic [11:0] pixel_y,
    input  logic [15:0] color_sample,
    output logic [11:0] ball_x,
    output logic [11:0] ball_y,
    output logic        ball_found,
    output logic        ball_valid,
    output logic        busy,
    output logic        overrun
`ifdef COLOR_BLOB_MASK_OUT_EN
    ,
    output logic        match_mask,
    output logic        match_mask_valid
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DIVIDE = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  iter_q;

    logic [31:0] sum_x_q, sum_y_q;
    logic [16:0] count_q;

    logic [31:0] qx_q, qy_q;
    logic [16:0] rx_q, ry_q;
    logic [16:0] div_q;
    logic        det_q;

    logic [11:0] ball_x_q, ball_y_q;
    logic        ball_found_q, ball_valid_q, overrun_q;

    // ---------------- pixel classification ----------------
    logic [7:0]  w_cr, w_cb, w_cr_ref, w_cb_ref, w_dcr, w_dcb;
    logic        w_match, w_qualify, w_frame_end;
    logic [31:0] w_sum_x_next, w_sum_y_next;
    logic [16:0] w_count_next;

    assign w_cr     = CrCb[15:8];
    assign w_cb     = CrCb[7:0];
    assign w_cr_ref = color_sample[15:8];
    assign w_cb_ref = color_sample[7:0];
    assign w_dcr    = (w_cr >= w_cr_ref) ? (w_cr - w_cr_ref) : (w_cr_ref - w_cr);
    assign w_dcb    = (w_cb >= w_cb_ref) ? (w_cb - w_cb_ref) : (w_cb_ref - w_cb);
    assign w_match  = (w_dcr <= 8'(TOL)) && (w_dcb <= 8'(TOL));

    assign w_qualify   = shift_clk_en && en && w_match &&
                         (pixel_x < 12'(H_ACTIVE)) && (pixel_y < 12'(V_ACTIVE));
    assign w_frame_end = shift_clk_en && (pixel_x == 12'(H_ACTIVE - 1)) &&
                         (pixel_y == 12'(V_ACTIVE - 1));

    // Snapshot includes the frame-end pixel's own contribution.
    assign w_sum_x_next = sum_x_q + (w_qualify ? 32'(pixel_x) : 32'd0);
    assign w_sum_y_next = sum_y_q + (w_qualify ? 32'(pixel_y) : 32'd0);
    assign w_count_next = count_q + (w_qualify ? 17'd1 : 17'd0);

    // ---------------- restoring divider step ----------------
    logic [17:0] w_trial_x, w_trial_y;
    logic        w_ge_x, w_ge_y;
    logic [16:0] w_rem_x, w_rem_y;

    assign w_trial_x = {rx_q, qx_q[31]};
    assign w_trial_y = {ry_q, qy_q[31]};
    assign w_ge_x    = w_trial_x >= {1'b0, div_q};
    assign w_ge_y    = w_trial_y >= {1'b0, div_q};
    // Remainder always stays below the divisor, so 17 bits suffice.
    assign w_rem_x   = w_ge_x ? (w_trial_x[16:0] - div_q) : w_trial_x[16:0];
    assign w_rem_y   = w_ge_y ? (w_trial_y[16:0] - div_q) : w_trial_y[16:0];

    // ---------------- FSM ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (w_frame_end) state_d = S_DIVIDE;
            S_DIVIDE: if (iter_q == 6'd32) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_100M) begin
        if (rst_p) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // ---------------- accumulators ----------------
    always_ff @(posedge clk_100M) begin
        if (rst_p || w_frame_end) begin
            sum_x_q <= 32'd0;
            sum_y_q <= 32'd0;
            count_q <= 17'd0;
        end else begin
            sum_x_q <= w_sum_x_next;
            sum_y_q <= w_sum_y_next;
            count_q <= w_count_next;
        end
    end

    // ---------------- divider and result registers ----------------
    always_ff @(posedge clk_100M) begin
        if (rst_p) begin
            iter_q       <= 6'd0;
            qx_q         <= 32'd0;
            qy_q         <= 32'd0;
            rx_q         <= 17'd0;
            ry_q         <= 17'd0;
            div_q        <= 17'd0;
            det_q        <= 1'b0;
            ball_x_q     <= 12'd0;
            ball_y_q     <= 12'd0;
            ball_found_q <= 1'b0;
            ball_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            ball_valid_q <= 1'b0;
            if (w_frame_end && state_q != S_IDLE) overrun_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (w_frame_end) begin
                        qx_q   <= w_sum_x_next;
                        qy_q   <= w_sum_y_next;
                        rx_q   <= 17'd0;
                        ry_q   <= 17'd0;
                        div_q  <= w_count_next;
                        det_q  <= (w_count_next >= 17'(MIN_COUNT));
                        iter_q <= 6'd0;
                    end
                end
                S_DIVIDE: begin
                    if (iter_q != 6'd32) begin
                        iter_q <= iter_q + 6'd1;
                        // Small counts skip the arithmetic entirely; no divide by zero.
                        if (det_q) begin
                            qx_q <= {qx_q[30:0], w_ge_x};
                            qy_q <= {qy_q[30:0], w_ge_y};
                            rx_q <= w_rem_x;
                            ry_q <= w_rem_y;
                        end
                    end
                end
                S_DONE: begin
                    ball_valid_q <= 1'b1;
                    ball_found_q <= det_q;
                    if (det_q) begin
                        ball_x_q <= qx_q[11:0];
                        ball_y_q <= qy_q[11:0];
                    end
                end
                default: ;
            endcase
        end
    end

    assign ball_x     = ball_x_q;
    assign ball_y     = ball_y_q;
    assign ball_found = ball_found_q;
    assign ball_valid = ball_valid_q;
    assign busy       = (state_q == S_DIVIDE);
    assign overrun    = overrun_q;

`ifdef COLOR_BLOB_MASK_OUT_EN
    logic match_mask_q, match_mask_valid_q;

    always_ff @(posedge clk_100M) begin
        if (rst_p) begin
            match_mask_q       <= 1'b0;
            match_mask_valid_q <= 1'b0;
        end else begin
            match_mask_q       <= w_match && en;
            match_mask_valid_q <= shift_clk_en;
        end
    end

    assign match_mask       = match_mask_q;
    assign match_mask_valid = match_mask_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_color_blob_locator.sv
`default_nettype none
// ============================================================================
// Module   : tb_color_blob_locator
// Brief    : Directed frame vectors for color_blob_locator plus overrun and
//            mid-divide reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_color_blob_locator;

    logic        clk_100M = 1'b0;
    logic        rst_p = 1'b1;
    logic        en = 1'b0;
    logic        shift_clk_en = 1'b0;
    logic [15:0] CrCb = 16'h0;
    logic [11:0] pixel_x = 12'd0;
    logic [11:0] pixel_y = 12'd0;
    logic [15:0] color_sample = 16'h0;
    logic [11:0] ball_x, ball_y;
    logic        ball_found, ball_valid, busy, overrun;

    int checks = 0;
    int errors = 0;

    color_blob_locator dut (
        .clk_100M     (clk_100M),
        .rst_p        (rst_p),
        .en           (en),
        .shift_clk_en (shift_clk_en),
        .CrCb         (CrCb),
        .pixel_x      (pixel_x),
        .pixel_y      (pixel_y),
        .color_sample (color_sample),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .ball_found   (ball_found),
        .ball_valid   (ball_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    always #5 clk_100M = ~clk_100M;

    typedef struct {
        logic [15:0] ref_c;
        logic [15:0] pix;
        int          x0, y0, w, n;
        logic        en;
        logic        extra;
        int          ex, ey, ef;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at #1 after a rising edge; presents one pixel for exactly one edge.
    task automatic drive_pix(input int x, input int y, input logic [15:0] c);
        pixel_x      = 12'(x);
        pixel_y      = 12'(y);
        CrCb         = c;
        shift_clk_en = 1'b1;
        @(posedge clk_100M);
        #1;
        shift_clk_en = 1'b0;
    endtask

    task automatic stream_blob(input vec_t v);
        color_sample = v.ref_c;
        en           = v.en;
        for (int i = 0; i < v.n; i++)
            drive_pix(v.x0 + (i % v.w), v.y0 + (i / v.w), v.pix);
        if (v.extra) drive_pix(300, 200, 16'h9180);
        drive_pix(319, 239, 16'h2020);
    endtask

    // Observes the result window following a frame end; optional second frame end at cycle fe2.
    task automatic watch_result(input string tag, input int fe2, input int ex, input int ey, input int ef);
        int lat = -1;
        int pulses = 0;
        int cx = 0, cy = 0, cf = 0;
        for (int k = 1; k <= 80; k++) begin
            if (k == fe2) begin
                pixel_x = 12'd319; pixel_y = 12'd239; CrCb = 16'h2020;
                shift_clk_en = 1'b1;
            end
            @(posedge clk_100M);
            #1;
            shift_clk_en = 1'b0;
            if (k == 1) check({tag, " busy"}, int'(busy), 1);
            if (ball_valid) begin
                pulses++;
                if (lat < 0) begin
                    lat = k; cx = int'(ball_x); cy = int'(ball_y); cf = int'(ball_found);
                end
            end
        end
        check({tag, " latency"}, lat, 34);
        check({tag, " pulses"}, pulses, 1);
        check({tag, " ball_x"}, cx, ex);
        check({tag, " ball_y"}, cy, ey);
        check({tag, " ball_found"}, cf, ef);
        check({tag, " busy_end"}, int'(busy), 0);
    endtask

    vec_t vecs[7];
    vec_t v;

    initial begin
        //         ref       pix       x0   y0  w   n    en    extra ex   ey  ef
        vecs[0] = '{16'h9060, 16'h9262, 100, 50, 10, 100, 1'b1, 1'b0, 104, 54, 1};
        vecs[1] = '{16'h9060, 16'h9262, 100, 50, 10, 63,  1'b1, 1'b0, 104, 54, 0};
        vecs[2] = '{16'h8080, 16'h9090, 10,  5,  64, 64,  1'b1, 1'b0, 41,  5,  1};
        vecs[3] = '{16'h8080, 16'h9090, 10,  5,  64, 63,  1'b1, 1'b1, 41,  5,  0};
        vecs[4] = '{16'h9060, 16'h9262, 100, 50, 10, 100, 1'b0, 1'b0, 41,  5,  0};
        vecs[5] = '{16'h9060, 16'h9262, 100, 50, 10, 100, 1'b1, 1'b0, 104, 54, 1};
        vecs[6] = '{16'h8080, 16'h7070, 20,  7,  64, 64,  1'b1, 1'b0, 51,  7,  1};

        repeat (3) @(posedge clk_100M);
        #1;
        check("rst ball_x", int'(ball_x), 0);
        check("rst ball_y", int'(ball_y), 0);
        check("rst found", int'(ball_found), 0);
        check("rst valid", int'(ball_valid), 0);
        check("rst busy", int'(busy), 0);
        check("rst overrun", int'(overrun), 0);
        rst_p = 1'b0;
        @(posedge clk_100M);
        #1;

        for (int t = 0; t < 7; t++) begin
            stream_blob(vecs[t]);
            watch_result($sformatf("vec%0d", t), 0, vecs[t].ex, vecs[t].ey, vecs[t].ef);
        end
        check("no overrun", int'(overrun), 0);

        // Second frame end 10 cycles into the divide.
        v = '{16'h9060, 16'h9262, 200, 100, 10, 100, 1'b1, 1'b0, 204, 104, 1};
        stream_blob(v);
        watch_result("ovr", 10, 204, 104, 1);
        check("ovr sticky", int'(overrun), 1);

        // Reset at cycle 15 of the divide.
        v = '{16'h9060, 16'h9262, 100, 50, 10, 100, 1'b1, 1'b0, 104, 54, 1};
        stream_blob(v);
        repeat (15) @(posedge clk_100M);
        #1;
        check("pre-rst busy", int'(busy), 1);
        rst_p = 1'b1;
        @(posedge clk_100M);
        #1;
        rst_p = 1'b0;
        check("abort busy", int'(busy), 0);
        check("abort ball_x", int'(ball_x), 0);
        check("abort ball_y", int'(ball_y), 0);
        check("abort found", int'(ball_found), 0);
        check("abort overrun", int'(overrun), 0);
        begin
            int stray = 0;
            for (int k = 0; k < 50; k++) begin
                @(posedge clk_100M);
                #1;
                if (ball_valid) stray++;
            end
            check("abort no valid", stray, 0);
        end
        v = '{16'h9060, 16'h9262, 200, 100, 10, 100, 1'b1, 1'b0, 204, 104, 1};
        stream_blob(v);
        watch_result("post-rst", 0, 204, 104, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
